// File: rtl/blink_sequencer.sv
// LED blink sequencer: delay control, run/pause/limit-flash FSM,
// step-rate scheduler and four-mode LED pattern generator.
module blink_sequencer #(
  parameter int TICK_DIV   = 1250000,
  parameter int DELAY_INIT = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       faster,
  input  logic       slower,
  input  logic       pause,
  input  logic       mode_next,
  output logic [3:0] delay,
  output logic [1:0] mode,
  output logic [1:0] state,
  output logic       step_tick,
  output logic [3:0] led
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_PAUSED    = 2'd1,
    ST_FLASH_ON  = 2'd2,
    ST_FLASH_OFF = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [3:0]    delay_r, delay_s;
  logic [1:0]    mode_r, mode_s;
  logic [3:0]    pat_r, pat_s;
  logic          dir_down_r, dir_down_s;
  logic          ret_paused_r, ret_paused_s;
  logic [PW-1:0] presc_r, presc_s;
  logic [3:0]    sc_r, sc_s;
  logic          step_tick_r;
  logic [3:0]    led_r, led_s;
  logic [4:0]    adv_s;

  logic flashing_s, running_s, base_tick_s, step_raw_s, cmd_ok_s, limit_hit_s, step_evt_s;

  function automatic logic [3:0] pat_init(input logic [1:0] m);
    case (m)
      2'd0:    pat_init = 4'b0000;
      2'd1:    pat_init = 4'b0001;
      2'd2:    pat_init = 4'b0001;
      2'd3:    pat_init = 4'b0101;
      default: pat_init = 4'b0000;
    endcase
  endfunction

  // Returns {dir_down, pattern} for the next step of mode m.
  function automatic logic [4:0] pat_advance(input logic [1:0] m, input logic [3:0] p,
                                             input logic down);
    logic [3:0] np;
    logic       nd;
    np = p;
    nd = down;
    case (m)
      2'd0: np = p + 4'd1;
      2'd1: np = {p[2:0], p[3]};
      2'd2: begin
        if (!down) begin
          np = {p[2:0], 1'b0};
          nd = (np == 4'b1000);
        end else begin
          np = {1'b0, p[3:1]};
          nd = (np != 4'b0001);
        end
        if (np == 4'b0000) begin
          np = 4'b0001;
          nd = 1'b0;
        end else begin
          np = np;
        end
      end
      2'd3:    np = ~p;
      default: np = p;
    endcase
    pat_advance = {nd, np};
  endfunction

  assign flashing_s  = state_r[1];
  assign running_s   = (state_r != ST_PAUSED);
  assign base_tick_s = running_s && (presc_r == PRESC_MAX);
  assign step_raw_s  = base_tick_s && (sc_r >= delay_r);
  assign cmd_ok_s    = !flashing_s && (faster ^ slower);
  assign limit_hit_s = cmd_ok_s && ((faster && (delay_r == 4'd0)) ||
                                    (slower && (delay_r == 4'd15)));
  assign step_evt_s  = step_raw_s && !limit_hit_s && !mode_next;

  // Next-state, counter, pattern and LED computation.
  always_comb begin
    delay_s      = delay_r;
    mode_s       = mode_r;
    pat_s        = pat_r;
    dir_down_s   = dir_down_r;
    ret_paused_s = ret_paused_r;
    state_s      = state_r;
    presc_s      = presc_r;
    sc_s         = sc_r;
    adv_s        = 5'd0;
    led_s        = 4'b0000;

    if (cmd_ok_s && !limit_hit_s) begin
      delay_s = faster ? (delay_r - 4'd1) : (delay_r + 4'd1);
    end else begin
      delay_s = delay_r;
    end

    if (limit_hit_s || mode_next) begin
      presc_s = '0;
      sc_s    = 4'd0;
    end else if (!running_s) begin
      presc_s = presc_r;
      sc_s    = sc_r;
    end else if (base_tick_s) begin
      presc_s = '0;
      sc_s    = step_raw_s ? 4'd0 : (sc_r + 4'd1);
    end else begin
      presc_s = presc_r + PW'(1);
      sc_s    = sc_r;
    end

    if (mode_next) begin
      mode_s     = mode_r + 2'd1;
      pat_s      = pat_init(mode_s);
      dir_down_s = 1'b0;
    end else if (step_evt_s && (state_r == ST_RUN)) begin
      adv_s      = pat_advance(mode_r, pat_r, dir_down_r);
      dir_down_s = adv_s[4];
      pat_s      = adv_s[3:0];
    end else begin
      pat_s = pat_r;
    end

    // A pause arriving during a flash only retargets where the flash returns to.
    case (state_r)
      ST_RUN, ST_PAUSED: begin
        if (limit_hit_s) begin
          ret_paused_s = (state_r == ST_PAUSED) ^ pause;
          state_s      = ST_FLASH_ON;
        end else if (pause) begin
          state_s = (state_r == ST_RUN) ? ST_PAUSED : ST_RUN;
        end else begin
          state_s = state_r;
        end
      end
      ST_FLASH_ON: begin
        ret_paused_s = ret_paused_r ^ pause;
        state_s      = step_evt_s ? ST_FLASH_OFF : ST_FLASH_ON;
      end
      ST_FLASH_OFF: begin
        ret_paused_s = ret_paused_r ^ pause;
        if (step_evt_s) begin
          state_s = ret_paused_s ? ST_PAUSED : ST_RUN;
        end else begin
          state_s = ST_FLASH_OFF;
        end
      end
      default: state_s = ST_RUN;
    endcase

    case (state_s)
      ST_FLASH_ON:  led_s = 4'b1111;
      ST_FLASH_OFF: led_s = 4'b0000;
      default:      led_s = pat_s;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_RUN;
      delay_r      <= 4'(DELAY_INIT);
      mode_r       <= 2'd0;
      pat_r        <= 4'b0000;
      dir_down_r   <= 1'b0;
      ret_paused_r <= 1'b0;
      presc_r      <= '0;
      sc_r         <= 4'd0;
      step_tick_r  <= 1'b0;
      led_r        <= 4'b0000;
    end else begin
      state_r      <= state_s;
      delay_r      <= delay_s;
      mode_r       <= mode_s;
      pat_r        <= pat_s;
      dir_down_r   <= dir_down_s;
      ret_paused_r <= ret_paused_s;
      presc_r      <= presc_s;
      sc_r         <= sc_s;
      step_tick_r  <= step_evt_s;
      led_r        <= led_s;
    end
  end

  assign delay     = delay_r;
  assign mode      = mode_r;
  assign state     = state_r;
  assign step_tick = step_tick_r;
  assign led       = led_r;

endmodule

// File: tb/tb_blink_sequencer.sv
// Directed bench for blink_sequencer with a behavioural model compared every cycle.
module tb_blink_sequencer;
  localparam int TD = 4;
  localparam int DI = 8;

  logic       clk = 1'b0;
  bit         clk_run = 1'b1;
  logic       reset_n = 1'b0;
  logic       faster = 1'b0, slower = 1'b0, pause = 1'b0, mode_next = 1'b0;
  logic [3:0] delay, led;
  logic [1:0] mode, state;
  logic       step_tick;

  int errors = 0;
  int checks = 0;

  blink_sequencer #(.TICK_DIV(TD), .DELAY_INIT(DI)) dut (
    .clk(clk), .reset_n(reset_n), .faster(faster), .slower(slower),
    .pause(pause), .mode_next(mode_next), .delay(delay), .mode(mode),
    .state(state), .step_tick(step_tick), .led(led)
  );

  always #5 if (clk_run) clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: elapsed clocks in the current interval, pattern as a position in each mode's cycle.
  int         m_delay, m_mode, m_state, m_ret, m_elapsed, m_pos;
  logic [3:0] m_led;
  logic       m_tick;

  function automatic int plen(input int md);
    case (md)
      0: plen = 16;
      1: plen = 4;
      2: plen = 6;
      default: plen = 2;
    endcase
  endfunction

  function automatic logic [3:0] pat_of(input int md, input int pos);
    logic [3:0] r;
    r = 4'd0;
    case (md)
      0: r = 4'(pos);
      1: r = 4'(1 << pos);
      2: case (pos)
           0: r = 4'd1; 1: r = 4'd2; 2: r = 4'd4;
           3: r = 4'd8; 4: r = 4'd4; default: r = 4'd2;
         endcase
      default: r = (pos == 0) ? 4'b0101 : 4'b1010;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_delay <= DI; m_mode <= 0; m_state <= 0; m_ret <= 0;
      m_elapsed <= 0; m_pos <= 0; m_led <= 4'd0; m_tick <= 1'b0;
    end else begin : mdl
      int d, md, st, rt, el, ps;
      bit step, hit, flash, run;
      d = m_delay; md = m_mode; st = m_state; rt = m_ret; ps = m_pos;
      flash = (m_state >= 2);
      run   = (m_state != 1);
      step  = run && ((m_elapsed + 1) % TD == 0) && ((m_elapsed + 1) / TD >= m_delay + 1);
      hit   = !flash && (faster != slower) &&
              ((faster && m_delay == 0) || (slower && m_delay == 15));
      if (mode_next || hit) step = 1'b0;
      if (!flash && (faster != slower) && !hit) d = faster ? d - 1 : d + 1;
      if (mode_next) begin
        md = (md + 1) % 4; ps = 0;
      end else if (step && m_state == 0) begin
        ps = (ps + 1) % plen(md);
      end
      if (flash) begin
        if (pause) rt = 1 - rt;
        if (step) st = (m_state == 2) ? 3 : rt;
      end else if (hit) begin
        rt = pause ? 1 - m_state : m_state;
        st = 2;
      end else if (pause) begin
        st = 1 - m_state;
      end
      el = (mode_next || hit || step) ? 0 : (run ? m_elapsed + 1 : m_elapsed);
      m_delay <= d; m_mode <= md; m_state <= st; m_ret <= rt; m_pos <= ps;
      m_elapsed <= el; m_tick <= step;
      m_led <= (st == 2) ? 4'hF : (st == 3) ? 4'h0 : pat_of(md, ps);
    end
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      chk("cyc_led", led, m_led);
      chk("cyc_state", state, m_state);
      chk("cyc_delay", delay, m_delay);
      chk("cyc_mode", mode, m_mode);
      chk("cyc_step_tick", step_tick, m_tick);
    end
  end

  task automatic pulse(input bit f, input bit s, input bit p, input bit m);
    @(posedge clk); #1;
    faster = f; slower = s; pause = p; mode_next = m;
    @(posedge clk); #1;
    faster = 1'b0; slower = 1'b0; pause = 1'b0; mode_next = 1'b0;
  endtask

  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!step_tick && n < 3000);
    if (!step_tick) chk("step_timeout", 0, 1);
  endtask

  initial begin
    int n;
    int ticks;
    logic [3:0] exp_pp [6];
    exp_pp[0] = 4'b0010; exp_pp[1] = 4'b0100; exp_pp[2] = 4'b1000;
    exp_pp[3] = 4'b0100; exp_pp[4] = 4'b0010; exp_pp[5] = 4'b0001;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_led", led, 0); chk("rst_state", state, 0); chk("rst_delay", delay, 8);
    chk("rst_mode", mode, 0); chk("rst_tick", step_tick, 0);
    reset_n = 1'b1;

    // Binary up-count at 36-clock period.
    for (int i = 1; i <= 16; i++) begin
      wait_step(n);
      chk("run_period", n, 36);
      if (i == 1) chk("first_led", led, 1);
      if (i == 3) chk("third_led", led, 3);
    end
    chk("wrap_led", led, 0);
    wait_step(n);
    chk("after_wrap_led", led, 1);

    // Pause 10 clocks into an interval, hold 200 clocks, resume.
    repeat (8) @(posedge clk);
    pulse(0, 0, 1, 0);
    chk("paused_state", state, 1);
    ticks = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (step_tick) ticks++;
    end
    chk("paused_ticks", ticks, 0);
    chk("paused_led", led, 1);
    pulse(0, 0, 1, 0);
    chk("resumed_state", state, 0);
    wait_step(n);
    chk("resume_remaining", n, 26);
    chk("resume_led", led, 2);

    // Slower to the limit, then a flash.
    repeat (7) pulse(0, 1, 0, 0);
    chk("delay_max", delay, 15);
    pulse(0, 1, 0, 0);
    chk("flash_on_state", state, 2); chk("flash_on_led", led, 15);
    wait_step(n);
    chk("flash_on_len", n, 64); chk("flash_off_state", state, 3); chk("flash_off_led", led, 0);
    wait_step(n);
    chk("flash_off_len", n, 64); chk("flash_ret_state", state, 0);
    chk("flash_ret_led", led, 2); chk("flash_delay", delay, 15);

    // Ping-pong mode.
    pulse(0, 0, 0, 1);
    pulse(0, 0, 0, 1);
    chk("mode2", mode, 2); chk("mode2_init", led, 1);
    for (int i = 0; i < 6; i++) begin
      wait_step(n);
      chk("pp_period", n, 64);
      chk("pp_led", led, exp_pp[i]);
    end

    // Simultaneous faster/slower, then faster down to the limit with pause in flash.
    repeat (7) pulse(1, 0, 0, 0);
    chk("delay_8", delay, 8);
    pulse(1, 1, 0, 0);
    chk("both_ignored", delay, 8);
    repeat (8) pulse(1, 0, 0, 0);
    chk("delay_0", delay, 0);
    pulse(1, 0, 0, 0);
    chk("low_flash_state", state, 2); chk("low_flash_delay", delay, 0);
    pulse(0, 0, 1, 0);
    chk("pause_in_flash", state, 2);
    wait_step(n);
    chk("low_flash_on_rem", n, 2); chk("low_flash_off", state, 3);
    wait_step(n);
    chk("low_flash_off_len", n, 4); chk("ret_paused", state, 1);
    ticks = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (step_tick) ticks++;
    end
    chk("ret_paused_ticks", ticks, 0);

    // Limit hit from PAUSED, mode change hidden by flash, then async reset.
    pulse(1, 0, 0, 0);
    chk("paused_hit_state", state, 2);
    pulse(0, 0, 0, 1);
    chk("flash_mode3", mode, 3); chk("flash_hides_mode", led, 15);
    @(negedge clk);
    clk_run = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async_led", led, 0); chk("async_state", state, 0); chk("async_delay", delay, 8);
    chk("async_mode", mode, 0); chk("async_tick", step_tick, 0);
    #5 clk_run = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    wait_step(n);
    chk("post_rst_period", n, 36); chk("post_rst_led", led, 1);

    // pause and mode_next together.
    pulse(0, 0, 1, 1);
    chk("pm_state", state, 1); chk("pm_mode", mode, 1); chk("pm_led", led, 1);
    repeat (10) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/blink_sequencer.md
Name: blink_sequencer

Overview:
- Control block for the LED blink datapath. Replaces the split delay-control/blinker pair with one sequencer.
- Consumes one-cycle key command pulses from the oneshot stage: faster, slower, pause, mode_next.
- Owns the blink delay, a run/pause/limit-flash state machine, a step-rate scheduler and a 4-mode LED pattern generator.
- Drives the board LEDs directly.

Parameters:
- TICK_DIV, 1250000, clocks per base tick (25 ms at 50 MHz); minimum 2.
- DELAY_INIT, 8, delay value loaded at reset; range 0..15.

Ports:
- clk  input  1  system clock (CLOCK_50 at top level)
- reset_n  input  1  reset; one clock, reset is asynchronous and active-low
- faster  input  1  one-cycle pulse, decrement delay
- slower  input  1  one-cycle pulse, increment delay
- pause  input  1  one-cycle pulse, toggle run/pause
- mode_next  input  1  one-cycle pulse, advance pattern mode
- delay  output  4  current delay, 0..15
- mode  output  2  current pattern mode
- state  output  2  FSM state: 0 RUN, 1 PAUSED, 2 FLASH_ON, 3 FLASH_OFF
- step_tick  output  1  one-cycle pulse on each pattern step
- led  output  4  LED drive

Behaviour:
- Reset (async, reset_n=0), all registered:
  - delay=DELAY_INIT, mode=0, state=RUN, led=0000, step_tick=0.
  - Prescaler, step counter, saved pattern, saved return state and ping-pong direction all cleared (direction=up).
- Scheduler:
  - Prescaler counts 0..TICK_DIV-1; base_tick is the cycle where prescaler = TICK_DIV-1.
  - Step counter sc increments on base_tick.
  - Step event: base_tick AND sc >= delay. On a step event, sc <= 0.
  - Step period is therefore (delay+1)*TICK_DIV clocks.
  - A delay reduction mid-interval fires on the next base_tick.
  - Prescaler and sc are frozen in PAUSED; they run in RUN, FLASH_ON and FLASH_OFF.
- Step outputs:
  - step_tick is registered: high for exactly the cycle after the step edge.
  - led updates on the same edge, so led and step_tick change together.
- Delay:
  - faster with delay>0: delay-1.
  - slower with delay<15: delay+1.
  - faster at 0, or slower at 15: delay unchanged; enter FLASH_ON.
  - faster and slower in the same cycle: both ignored.
  - Delay updates are visible on delay the next cycle.
  - Delay commands are ignored while in FLASH_ON or FLASH_OFF.
- Patterns (pattern register P, advanced on each step event in RUN):
  - mode0, binary up-count: init 0000, wraps 1111 -> 0000.
  - mode1, rotate-left one-hot: init 0001; sequence 0001, 0010, 0100, 1000, 0001.
  - mode2, ping-pong: init 0001, dir up; reverses at 1000 and 0001. Sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, ...
  - mode3, alternate: init 0101; toggles 0101 <-> 1010.
  - mode_next: mode <= mode+1 (wraps 3 -> 0), P <= new mode's init value, dir <= up, prescaler and sc cleared. Accepted in any state.
- FSM:
  - RUN: led=P. pause -> PAUSED.
  - PAUSED: led=P, held frozen. pause -> RUN, resuming the remaining interval.
  - Limit hit (from RUN or PAUSED):
    - Save the current state as the return target.
    - Go to FLASH_ON.
    - prescaler and sc cleared.
    - P is not advanced.
  - FLASH_ON: led=1111; next step event -> FLASH_OFF.
  - FLASH_OFF: led=0000; next step event -> return target, with led=P on that edge.
  - pause during FLASH_ON or FLASH_OFF toggles the return target between RUN and PAUSED; there is no immediate state change.
  - mode_next during flash updates P and mode, but the change is invisible until the flash ends.
  - step_tick also pulses on step events in FLASH_ON and FLASH_OFF.
- Simultaneous pulses:
  - pause and mode_next in the same cycle: both applied.
  - A limit hit in the same cycle as pause: the flash is entered, and the pause toggles the saved return target.

Test Plan:
- Setup for all scenarios: TICK_DIV=4, DELAY_INIT=8, so the period is 36 clocks.
- Release reset, hold inputs low -> step_tick every 36 clocks. led counts 0001, 0010, 0011, ...; after 16 steps led=0000.
- slower x7 -> delay=15, period 64 clocks. 8th slower -> state=2, led=1111 for 64 clocks, then state=3, led=0000 for 64 clocks, then state=0 with led=pre-flash P; delay stays 15.
- pause at 10 clocks into an interval -> state=1, led frozen, no step_tick for 200 clocks. pause again -> next step_tick after 26 more clocks.
- mode_next x2 -> mode=2, led=0001 the next cycle. Steps then give 0010, 0100, 1000, 0100, 0010, 0001.
- faster and slower in the same cycle at delay=8 -> delay stays 8. Then faster x8 -> 0; faster again -> flash. pause during FLASH_ON -> after FLASH_OFF, state=1 and led frozen.
- Assert reset_n mid-FLASH_ON with clk stopped -> led=0000, state=0, delay=8, mode=0 immediately.
